// File: rtl/data_io_ext.sv
// data_io_ext: receives file downloads over the IO-controller SPI link and
// streams them to a memory sink as DW-bit little-endian words.
//
// Ports
//   clk_sys, reset_n          system clock, async active-low reset
//   SPI_SCK/SPI_SS2/SPI_DI    async SPI (SS2 active low, MSB first)
//   ioctl_download            download in progress
//   ioctl_index               menu index of the file being loaded
//   ioctl_we/addr/dout/be     word write port (addr aligned to DW/8)
//   ioctl_wait                sink back-pressure, blocks writes while high
//   ioctl_size                byte count of the last completed download
//   ioctl_ovf                 sticky: a payload byte was dropped (FIFO full)
//
// state | meaning
// IDLE  | no download; 0x54 payload is discarded
// RUN   | 0x54 payload is queued and packed into words
// FLUSH | end received; drain FIFO, write any partial word
// DONE  | size latched, download cleared; back to IDLE next cycle
module data_io_ext #(
    parameter int              DW      = 16,
    parameter int              AW      = 25,
    parameter int              FIFO_AW = 4,
    parameter logic [AW-1:0]   BASE0   = 25'h0E0000,
    parameter logic [AW-1:0]   BASE1   = 25'h100000,
    parameter logic [AW-1:0]   BASEX   = 25'h120000
) (
    input  logic               clk_sys,
    input  logic               reset_n,
    input  logic               SPI_SCK,
    input  logic               SPI_SS2,
    input  logic               SPI_DI,
    output logic               ioctl_download,
    output logic [7:0]         ioctl_index,
    output logic               ioctl_we,
    input  logic               ioctl_wait,
    output logic [AW-1:0]      ioctl_addr,
    output logic [DW-1:0]      ioctl_dout,
    output logic [DW/8-1:0]    ioctl_be,
    output logic [AW-1:0]      ioctl_size,
    output logic               ioctl_ovf
);

    localparam int BPW   = DW / 8;
    localparam int LW    = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [AW-1:0]    ALIGN_MASK = ~(AW'(BPW - 1));
    localparam logic [FIFO_AW:0] PTR_ONE    = (FIFO_AW + 1)'(1);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    // SPI receiver
    logic [2:0] sck_q;
    logic [1:0] ss_q;
    logic [1:0] di_q;
    logic [2:0] bit_cnt_q;
    logic [6:0] shift_q;
    logic       have_cmd_q;
    logic [7:0] cmd_q;
    logic       rx_stb_q;
    logic [7:0] rx_byte_q;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            sck_q      <= '0;
            ss_q       <= '1;
            di_q       <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            have_cmd_q <= 1'b0;
            cmd_q      <= '0;
            rx_stb_q   <= 1'b0;
            rx_byte_q  <= '0;
        end else begin
            sck_q    <= {sck_q[1:0], SPI_SCK};
            ss_q     <= {ss_q[0], SPI_SS2};
            di_q     <= {di_q[0], SPI_DI};
            rx_stb_q <= 1'b0;
            if (ss_q[1]) begin
                bit_cnt_q  <= '0;
                have_cmd_q <= 1'b0;
            end else if (sck_q[1] && !sck_q[2]) begin
                // DI and SCK share the same synchroniser depth, so di_q[1]
                // is the bit that was on the wire when SCK rose.
                shift_q   <= {shift_q[5:0], di_q[1]};
                bit_cnt_q <= bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    if (!have_cmd_q) begin
                        cmd_q      <= {shift_q, di_q[1]};
                        have_cmd_q <= 1'b1;
                    end else begin
                        rx_stb_q  <= 1'b1;
                        rx_byte_q <= {shift_q, di_q[1]};
                    end
                end
            end
        end
    end

    // Datapath / FSM registers
    state_t             state_q, state_d;
    logic [7:0]         index_q, index_d;
    logic               dl_q, dl_d;
    logic [AW-1:0]      size_q, size_d;
    logic               ovf_q, ovf_d;
    logic [AW-1:0]      cnt_q, cnt_d;
    logic [AW-1:0]      addr_q, addr_d;
    logic [DW-1:0]      word_q, word_d;
    logic [BPW-1:0]     be_q, be_d;
    logic [LW-1:0]      lane_q, lane_d;
    logic               pend_q, pend_d;
    logic [FIFO_AW:0]   wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW:0]   rd_ptr_q, rd_ptr_d;
    logic [7:0]         mem_q [DEPTH];

    logic               fifo_empty, fifo_full, active, word_rdy, we, push;
    logic [7:0]         pop_byte;
    logic [AW-1:0]      base;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                        (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
    assign pop_byte   = mem_q[rd_ptr_q[FIFO_AW-1:0]];

    always_comb begin
        state_d  = state_q;
        index_d  = index_q;
        dl_d     = dl_q;
        size_d   = size_q;
        ovf_d    = ovf_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        word_d   = word_q;
        be_d     = be_q;
        lane_d   = lane_q;
        pend_d   = pend_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        push     = 1'b0;

        case (index_q)
            8'h00:   base = BASE0 & ALIGN_MASK;
            8'h01:   base = BASE1 & ALIGN_MASK;
            default: base = BASEX & ALIGN_MASK;
        endcase

        active = (state_q == RUN) || (state_q == FLUSH);
        // A partial word only counts as ready once FLUSH has drained the FIFO.
        word_rdy = pend_q || ((state_q == FLUSH) && fifo_empty && (be_q != '0));
        we       = active && word_rdy && !ioctl_wait;

        if (we) begin
            addr_d = addr_q + AW'(BPW);
            word_d = '0;
            be_d   = '0;
            lane_d = '0;
            pend_d = 1'b0;
        end else if (active && !pend_q && !ioctl_wait && !fifo_empty) begin
            for (int l = 0; l < BPW; l++) begin
                if (lane_q == LW'(l)) begin
                    word_d[l*8 +: 8] = pop_byte;
                    be_d[l]          = 1'b1;
                end
            end
            rd_ptr_d = rd_ptr_q + PTR_ONE;
            if (lane_q == LW'(BPW - 1)) begin
                pend_d = 1'b1;
                lane_d = '0;
            end else begin
                lane_d = lane_q + LW'(1);
            end
        end

        case (state_q)
            FLUSH: begin
                if (fifo_empty && !word_rdy) begin
                    state_d = DONE;
                    size_d  = cnt_q;
                    dl_d    = 1'b0;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = state_q;
        endcase

        if (rx_stb_q) begin
            case (cmd_q)
                8'h55: index_d = rx_byte_q;
                8'h53: begin
                    if (rx_byte_q[0]) begin
                        wr_ptr_d = '0;
                        rd_ptr_d = '0;
                        word_d   = '0;
                        be_d     = '0;
                        lane_d   = '0;
                        pend_d   = 1'b0;
                        cnt_d    = '0;
                        ovf_d    = 1'b0;
                        addr_d   = base;
                        dl_d     = 1'b1;
                        state_d  = RUN;
                    end else if (state_q == RUN) begin
                        state_d = FLUSH;
                    end
                end
                8'h54: begin
                    if (state_q == RUN) begin
                        if (fifo_full) begin
                            ovf_d = 1'b1;
                        end else begin
                            push     = 1'b1;
                            wr_ptr_d = wr_ptr_q + PTR_ONE;
                            cnt_d    = cnt_q + AW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            index_q  <= '0;
            dl_q     <= 1'b0;
            size_q   <= '0;
            ovf_q    <= 1'b0;
            cnt_q    <= '0;
            addr_q   <= '0;
            word_q   <= '0;
            be_q     <= '0;
            lane_q   <= '0;
            pend_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            index_q  <= index_d;
            dl_q     <= dl_d;
            size_q   <= size_d;
            ovf_q    <= ovf_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            word_q   <= word_d;
            be_q     <= be_d;
            lane_q   <= lane_d;
            pend_q   <= pend_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // FIFO storage carries no reset; emptiness is defined by the pointers.
    always_ff @(posedge clk_sys) begin
        if (push) begin
            mem_q[wr_ptr_q[FIFO_AW-1:0]] <= rx_byte_q;
        end
    end

    assign ioctl_download = dl_q;
    assign ioctl_index    = index_q;
    assign ioctl_we       = we;
    assign ioctl_addr     = addr_q;
    assign ioctl_dout     = word_q;
    assign ioctl_be       = be_q;
    assign ioctl_size     = size_q;
    assign ioctl_ovf      = ovf_q;

endmodule
